mem_io_responder: RTL and testbench

Responder end of the CPU's byte-wide memory bus. It serves the initiator's one-byte-per-cycle address/data/write transactions from an internal byte RAM. It also maps a small I/O window at 0x30000 onto a TX FIFO and an RX FIFO that face a UART-style stream interface. It drives `io_buffer_full` back to the initiator so stores to the UART port can be throttled.

---
 rtl/mem_io_responder_if.sv | 27 ++
 rtl/mem_io_responder.sv | 117 +++++++++++
 tb/tb_mem_io_responder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// Bus and stream signals between the CPU-side initiator, the UART-style stream and
// mem_io_responder.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        sim_done;
  logic        err_overflow;

  modport master (
    output mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, sim_done, err_overflow
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, sim_done, err_overflow
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte-wide memory responder: internal RAM plus an I/O window at 0x30000 mapping
// a TX FIFO, an RX FIFO, a status byte and a sim-done strobe.
module mem_io_responder #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FULL_MARGIN = 2
) (
  input logic               clk_in,
  input logic               rst_n_in,
  mem_io_responder_if.slave bus
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned RamSize = 2 ** ADDR_W;
  localparam logic [CntW-1:0] Depth      = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] FullThresh = CntW'(FIFO_DEPTH - FULL_MARGIN);

  logic [7:0] ram [RamSize];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];

  logic [PtrW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]      mem_din_q, rd_data;
  logic            sim_done_q, err_q;

  logic [17:0] addr;
  logic [2:0]  off;
  logic        io_sel, ram_sel;
  logic        tx_push_req, tx_push, tx_pop, tx_full;
  logic        rx_pop, rx_push, rx_nonempty;
  logic        sim_done_d, overflow;
  logic        unused_addr_hi;

  assign addr           = bus.mem_a[17:0];
  assign unused_addr_hi = ^bus.mem_a[31:18];
  assign off            = addr[2:0];
  assign io_sel         = addr[17:16] == 2'b11;
  assign ram_sel        = !io_sel && ({14'd0, addr} < 32'(RamSize));

  assign tx_full     = tx_cnt_q == Depth;
  assign rx_nonempty = rx_cnt_q != '0;

  assign tx_pop      = bus.tx_valid && bus.tx_ready;
  assign tx_push_req = io_sel && bus.mem_wr && (off == 3'd0);
  // A push into a full FIFO still lands when a pop frees a slot on the same edge.
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign overflow    = tx_push_req && tx_full && !tx_pop;
  assign sim_done_d  = io_sel && bus.mem_wr && (off == 3'd4);

  assign rx_pop  = io_sel && !bus.mem_wr && (off == 3'd0) && rx_nonempty;
  assign rx_push = bus.rx_valid && bus.rx_ready;

  assign bus.io_buffer_full = tx_cnt_q >= FullThresh;
  assign bus.tx_valid       = tx_cnt_q != '0;
  assign bus.tx_data        = tx_mem[tx_rd_q];
  // A bus pop of a full RX FIFO frees the slot the same cycle.
  assign bus.rx_ready       = (rx_cnt_q != Depth) || rx_pop;
  assign bus.mem_din        = mem_din_q;
  assign bus.sim_done       = sim_done_q;
  assign bus.err_overflow   = err_q;

  always_comb begin
    rd_data = 8'h00;
    if (ram_sel) begin
      rd_data = ram[addr[ADDR_W-1:0]];
    end else if (io_sel) begin
      case (off)
        3'd0:    rd_data = rx_nonempty ? rx_mem[rx_rd_q] : 8'h00;
        3'd4:    rd_data = {6'b0, rx_nonempty, tx_full};
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CntW'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CntW'(1);
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CntW'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CntW'(1);
  end

  // Storage arrays carry no reset; RAM contents survive a reset.
  always_ff @(posedge clk_in) begin
    if (ram_sel && bus.mem_wr) ram[addr[ADDR_W-1:0]] <= bus.mem_dout;
    if (tx_push) tx_mem[tx_wr_q] <= bus.mem_dout;
    if (rx_push) rx_mem[rx_wr_q] <= bus.rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      mem_din_q  <= 8'h00;
      sim_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PtrW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + PtrW'(1);
      if (rx_push) rx_wr_q <= rx_wr_q + PtrW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PtrW'(1);
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      sim_done_q <= sim_done_d;
      if (overflow)     err_q     <= 1'b1;
      if (!bus.mem_wr)  mem_din_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM, TX/RX FIFOs, status,
// sim_done and asynchronous reset behaviour.
module tb_mem_io_responder;

  localparam logic [31:0] IdleAddr = 32'h0002_0000;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  mem_io_responder_if bus_if ();

  mem_io_responder #(
    .ADDR_W     (17),
    .FIFO_DEPTH (16),
    .FULL_MARGIN(2)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus_if)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    bus_if.mem_a    = a;
    bus_if.mem_dout = d;
    bus_if.mem_wr   = 1'b1;
    tick();
    bus_if.mem_a  = IdleAddr;
    bus_if.mem_wr = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [7:0] exp);
    bus_if.mem_a  = a;
    bus_if.mem_wr = 1'b0;
    tick();
    check_eq(tag, {24'd0, bus_if.mem_din}, {24'd0, exp});
    bus_if.mem_a = IdleAddr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.mem_a    = IdleAddr;
    bus_if.mem_dout = 8'h00;
    bus_if.mem_wr   = 1'b0;
    bus_if.tx_ready = 1'b0;
    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b0;

    // Reset values
    repeat (2) @(posedge clk_in);
    #1;
    check_eq("rst_mem_din", {24'd0, bus_if.mem_din}, 32'h0);
    check_eq("rst_ibf", {31'd0, bus_if.io_buffer_full}, 32'h0);
    check_eq("rst_tx_valid", {31'd0, bus_if.tx_valid}, 32'h0);
    check_eq("rst_rx_ready", {31'd0, bus_if.rx_ready}, 32'h1);
    check_eq("rst_sim_done", {31'd0, bus_if.sim_done}, 32'h0);
    check_eq("rst_err", {31'd0, bus_if.err_overflow}, 32'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // RAM write then back-to-back reads
    for (int i = 0; i < 4; i++) bus_write(32'h100 + i, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) read_chk("ram_stream", 32'h100 + i, 8'(8'h11 * (i + 1)));

    // Overwrite, then out-of-range read, and hold on write
    bus_write(32'h200, 8'h55);
    read_chk("ram_pre", 32'h200, 8'h55);
    bus_write(32'h200, 8'hAA);
    read_chk("ram_new", 32'h200, 8'hAA);
    bus_write(32'h300, 8'h77);
    check_eq("din_hold_on_wr", {24'd0, bus_if.mem_din}, 32'hAA);
    read_chk("ram_hole", 32'h0002_0000, 8'h00);
    read_chk("upper_ignored", 32'hFFFC_0200, 8'hAA);

    // TX fill with sink stalled
    for (int i = 0; i < 17; i++) begin
      bus_write(32'h0003_0000, 8'(8'hA0 + i));
      if (i == 12) check_eq("ibf_13", {31'd0, bus_if.io_buffer_full}, 32'h0);
      if (i == 13) check_eq("ibf_14", {31'd0, bus_if.io_buffer_full}, 32'h1);
      if (i == 15) check_eq("err_at_16", {31'd0, bus_if.err_overflow}, 32'h0);
    end
    check_eq("err_overflow", {31'd0, bus_if.err_overflow}, 32'h1);
    read_chk("status_txfull", 32'h0003_0004, 8'h01);
    bus_if.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("tx_drain_data", {24'd0, bus_if.tx_data}, 32'(8'hA0 + i));
      check_eq("tx_drain_valid", {31'd0, bus_if.tx_valid}, 32'h1);
      tick();
    end
    check_eq("tx_empty", {31'd0, bus_if.tx_valid}, 32'h0);
    check_eq("ibf_clear", {31'd0, bus_if.io_buffer_full}, 32'h0);
    check_eq("err_sticky", {31'd0, bus_if.err_overflow}, 32'h1);
    bus_if.tx_ready = 1'b0;

    // RX basic
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = 8'h41;
    tick();
    bus_if.rx_data  = 8'h42;
    tick();
    bus_if.rx_valid = 1'b0;
    read_chk("rx_status", 32'h0003_0004, 8'h02);
    read_chk("rx_pop0", 32'h0003_0000, 8'h41);
    read_chk("rx_pop1", 32'h0003_0000, 8'h42);
    read_chk("rx_pop_empty", 32'h0003_0000, 8'h00);
    read_chk("rx_status_empty", 32'h0003_0004, 8'h00);
    read_chk("io_other", 32'h0003_0002, 8'h00);

    // RX full with simultaneous push and pop
    bus_if.rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_if.rx_data = 8'(8'h60 + i);
      tick();
    end
    bus_if.rx_valid = 1'b0;
    #1;
    check_eq("rx_full_ready", {31'd0, bus_if.rx_ready}, 32'h0);
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = 8'h7F;
    bus_if.mem_a    = 32'h0003_0000;
    bus_if.mem_wr   = 1'b0;
    #1;
    check_eq("rx_ready_on_pop", {31'd0, bus_if.rx_ready}, 32'h1);
    tick();
    check_eq("rx_full_pop", {24'd0, bus_if.mem_din}, 32'h60);
    bus_if.rx_valid = 1'b0;
    bus_if.mem_a    = IdleAddr;
    #1;
    check_eq("rx_still_full", {31'd0, bus_if.rx_ready}, 32'h0);
    for (int i = 1; i < 16; i++) read_chk("rx_order", 32'h0003_0000, 8'(8'h60 + i));
    read_chk("rx_new_byte", 32'h0003_0000, 8'h7F);
    read_chk("rx_drained", 32'h0003_0004, 8'h00);

    // sim_done pulse
    bus_write(32'h0003_0004, 8'hFF);
    check_eq("sim_done_hi", {31'd0, bus_if.sim_done}, 32'h1);
    tick();
    check_eq("sim_done_lo", {31'd0, bus_if.sim_done}, 32'h0);

    // Asynchronous reset during a TX drain
    for (int i = 0; i < 3; i++) bus_write(32'h0003_0000, 8'(8'hC0 + i));
    bus_if.tx_ready = 1'b1;
    tick();
    check_eq("pre_rst_valid", {31'd0, bus_if.tx_valid}, 32'h1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_eq("async_tx_valid", {31'd0, bus_if.tx_valid}, 32'h0);
    check_eq("async_err", {31'd0, bus_if.err_overflow}, 32'h0);
    check_eq("async_rx_ready", {31'd0, bus_if.rx_ready}, 32'h1);
    bus_if.tx_ready = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    read_chk("ram_keep_100", 32'h100, 8'h11);
    read_chk("ram_keep_200", 32'h200, 8'hAA);
    read_chk("ram_keep_300", 32'h300, 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
